// File: rtl/l2_host_req_tracker.sv
// l2_host_req_tracker: allocates host tags for L2 cache-line fetch requests,
// issues tagged host commands under command credits, and maps each tagged
// host response back to the originating stream ID.
module l2_host_req_tracker #(
    parameter int addr_width = 64,
    parameter int cache_line = 128,
    parameter int nstrms     = 64,
    parameter int ntags      = 32,
    parameter int ncredits   = 16,
    localparam int cache_line_width = $clog2(cache_line),
    localparam int nstrms_width     = $clog2(nstrms),
    localparam int ntags_width      = $clog2(ntags),
    localparam int crd_width        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req_v,
    output logic                    i_req_r,
    input  logic [nstrms_width-1:0] i_req_sid,
    input  logic [addr_width-1:0]   i_req_ea,
    output logic                    o_cmd_v,
    input  logic                    o_cmd_r,
    output logic [ntags_width-1:0]  o_cmd_tag,
    output logic [addr_width-1:0]   o_cmd_ea,
    input  logic                    i_crd_v,
    input  logic                    i_hrsp_v,
    output logic                    i_hrsp_r,
    input  logic [ntags_width-1:0]  i_hrsp_tag,
    output logic                    o_rsp_v,
    input  logic                    o_rsp_r,
    output logic [nstrms_width-1:0] o_rsp_sid,
    output logic                    o_idle,
    output logic                    o_err
);

    localparam logic [crd_width-1:0]  crd_init  = crd_width'(ncredits);
    localparam logic [addr_width-1:0] line_mask =
        {{(addr_width-cache_line_width){1'b1}}, {cache_line_width{1'b0}}};

    // Lowest-index set bit of the free bitmap; zero when nothing is free.
    function automatic logic [ntags_width-1:0] lowest_free(input logic [ntags-1:0] vec);
        logic [ntags_width-1:0] idx;
        idx = '0;
        for (int i = ntags - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ntags_width'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [ntags-1:0]        free_r;
    logic [ntags-1:0]        free_nxt_s;
    logic [nstrms_width-1:0] sid_tab_r [ntags];
    logic [crd_width-1:0]    crd_r;
    logic [crd_width-1:0]    crd_nxt_s;
    logic                    cmd_v_r;
    logic                    cmd_v_nxt_s;
    logic [ntags_width-1:0]  cmd_tag_r;
    logic [addr_width-1:0]   cmd_ea_r;
    logic                    rsp_v_r;
    logic                    rsp_v_nxt_s;
    logic [nstrms_width-1:0] rsp_sid_r;
    logic                    err_r;
    logic                    idle_r;
    logic [ntags_width-1:0]  alloc_tag_s;
    logic                    can_issue_s;
    logic                    req_fire_s;
    logic                    hrsp_rdy_s;
    logic                    hrsp_fire_s;
    logic                    hrsp_hit_s;
    logic                    hrsp_bad_s;
    logic                    crd_ovf_s;

    // Handshake decode and next-state computation for tags, credits and output valids.
    always_comb begin
        alloc_tag_s = lowest_free(free_r);
        can_issue_s = (|free_r) && (crd_r != {crd_width{1'b0}}) && (!cmd_v_r || o_cmd_r);
        req_fire_s  = i_req_v && can_issue_s;
        hrsp_rdy_s  = !rsp_v_r || o_rsp_r;
        hrsp_fire_s = i_hrsp_v && hrsp_rdy_s;
        hrsp_hit_s  = hrsp_fire_s && !free_r[i_hrsp_tag];
        hrsp_bad_s  = hrsp_fire_s && free_r[i_hrsp_tag];
        crd_ovf_s   = i_crd_v && !req_fire_s && (crd_r == crd_init);

        // Allocated and freed tags are always distinct, so both edits can apply.
        free_nxt_s = free_r;
        if (req_fire_s) begin
            free_nxt_s[alloc_tag_s] = 1'b0;
        end else begin
            free_nxt_s = free_nxt_s;
        end
        if (hrsp_hit_s) begin
            free_nxt_s[i_hrsp_tag] = 1'b1;
        end else begin
            free_nxt_s = free_nxt_s;
        end

        case ({req_fire_s, i_crd_v})
            2'b10:   crd_nxt_s = crd_r - {{(crd_width-1){1'b0}}, 1'b1};
            2'b01:   crd_nxt_s = crd_ovf_s ? crd_r : crd_r + {{(crd_width-1){1'b0}}, 1'b1};
            default: crd_nxt_s = crd_r;
        endcase

        if (req_fire_s) begin
            cmd_v_nxt_s = 1'b1;
        end else if (o_cmd_r) begin
            cmd_v_nxt_s = 1'b0;
        end else begin
            cmd_v_nxt_s = cmd_v_r;
        end

        if (hrsp_hit_s) begin
            rsp_v_nxt_s = 1'b1;
        end else if (o_rsp_r) begin
            rsp_v_nxt_s = 1'b0;
        end else begin
            rsp_v_nxt_s = rsp_v_r;
        end
    end

    // Tracker state and registered outputs; reset abandons all outstanding tags.
    always_ff @(posedge clk) begin
        if (reset) begin
            free_r    <= {ntags{1'b1}};
            crd_r     <= crd_init;
            cmd_v_r   <= 1'b0;
            cmd_tag_r <= '0;
            cmd_ea_r  <= '0;
            rsp_v_r   <= 1'b0;
            rsp_sid_r <= '0;
            err_r     <= 1'b0;
            idle_r    <= 1'b1;
        end else begin
            free_r  <= free_nxt_s;
            crd_r   <= crd_nxt_s;
            cmd_v_r <= cmd_v_nxt_s;
            rsp_v_r <= rsp_v_nxt_s;
            idle_r  <= (&free_nxt_s) && !cmd_v_nxt_s && !rsp_v_nxt_s;
            if (req_fire_s) begin
                cmd_tag_r <= alloc_tag_s;
                cmd_ea_r  <= i_req_ea & line_mask;
            end
            if (hrsp_hit_s) begin
                rsp_sid_r <= sid_tab_r[i_hrsp_tag];
            end
            if (hrsp_bad_s || crd_ovf_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Stream ID per tag, captured at allocation; contents are don't-care while free.
    always_ff @(posedge clk) begin
        if (req_fire_s) begin
            sid_tab_r[alloc_tag_s] <= i_req_sid;
        end
    end

    assign i_req_r   = can_issue_s;
    assign i_hrsp_r  = hrsp_rdy_s;
    assign o_cmd_v   = cmd_v_r;
    assign o_cmd_tag = cmd_tag_r;
    assign o_cmd_ea  = cmd_ea_r;
    assign o_rsp_v   = rsp_v_r;
    assign o_rsp_sid = rsp_sid_r;
    assign o_idle    = idle_r;
    assign o_err     = err_r;

endmodule

// File: tb/tb_l2_host_req_tracker.sv
// Bench for l2_host_req_tracker (default parameters: 32 tags, 16 credits).
// A reference model of the tag/credit/valid state predicts every output;
// expected commands and responses are queued on stimulus and popped at handshakes.
module tb_l2_host_req_tracker;

    logic        clk;
    logic        reset;
    logic        i_req_v;
    logic        i_req_r;
    logic [5:0]  i_req_sid;
    logic [63:0] i_req_ea;
    logic        o_cmd_v;
    logic        o_cmd_r;
    logic [4:0]  o_cmd_tag;
    logic [63:0] o_cmd_ea;
    logic        i_crd_v;
    logic        i_hrsp_v;
    logic        i_hrsp_r;
    logic [4:0]  i_hrsp_tag;
    logic        o_rsp_v;
    logic        o_rsp_r;
    logic [5:0]  o_rsp_sid;
    logic        o_idle;
    logic        o_err;

    l2_host_req_tracker dut (
        .clk(clk), .reset(reset),
        .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_sid(i_req_sid), .i_req_ea(i_req_ea),
        .o_cmd_v(o_cmd_v), .o_cmd_r(o_cmd_r), .o_cmd_tag(o_cmd_tag), .o_cmd_ea(o_cmd_ea),
        .i_crd_v(i_crd_v),
        .i_hrsp_v(i_hrsp_v), .i_hrsp_r(i_hrsp_r), .i_hrsp_tag(i_hrsp_tag),
        .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r), .o_rsp_sid(o_rsp_sid),
        .o_idle(o_idle), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model
    logic [31:0] m_free;
    logic [7:0]  m_crd;
    logic        m_cmd_v;
    logic        m_rsp_v;
    logic        m_err;
    logic [5:0]  m_sid [32];
    logic [68:0] cmd_q [$];
    logic [5:0]  rsp_q [$];

    function automatic logic [4:0] low_free(input logic [31:0] v);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 31; i >= 0; i--) if (v[i]) r = 5'(i);
        return r;
    endfunction

    task automatic model_reset();
        m_free = 32'hFFFF_FFFF; m_crd = 8'd16; m_cmd_v = 1'b0; m_rsp_v = 1'b0; m_err = 1'b0;
        cmd_q.delete(); rsp_q.delete();
    endtask

    // Drive one cycle (called at posedge+1), advance the model across the edge.
    task automatic drive(input logic req_v, input logic [5:0] sid, input logic [63:0] ea,
                         input logic cmd_r, input logic crd_v, input logic hv,
                         input logic [4:0] htag, input logic rsp_r);
        logic req_acc, h_acc, h_hit;
        logic [4:0] atag;
        i_req_v = req_v; i_req_sid = sid; i_req_ea = ea; o_cmd_r = cmd_r;
        i_crd_v = crd_v; i_hrsp_v = hv; i_hrsp_tag = htag; o_rsp_r = rsp_r;
        req_acc = req_v && (m_free != 32'd0) && (m_crd != 8'd0) && (!m_cmd_v || cmd_r);
        atag    = low_free(m_free);
        h_acc   = hv && (!m_rsp_v || rsp_r);
        h_hit   = h_acc && !m_free[htag];
        @(posedge clk);
        if (h_hit) begin
            rsp_q.push_back(m_sid[htag]); m_rsp_v = 1'b1; m_free[htag] = 1'b1;
        end else if (rsp_r) m_rsp_v = 1'b0;
        if (h_acc && !h_hit) m_err = 1'b1;
        if (req_acc) begin
            m_free[atag] = 1'b0; m_sid[atag] = sid; m_cmd_v = 1'b1;
            cmd_q.push_back({atag, ea & ~64'h7F});
        end else if (cmd_r) m_cmd_v = 1'b0;
        if (req_acc && !crd_v) m_crd = m_crd - 8'd1;
        else if (!req_acc && crd_v) begin
            if (m_crd == 8'd16) m_err = 1'b1;
            else m_crd = m_crd + 8'd1;
        end
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    endtask

    // Monitor: readiness/valid/status against the model, outputs against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            logic exp_rr;
            exp_rr = (m_free != 32'd0) && (m_crd != 8'd0) && (!m_cmd_v || o_cmd_r);
            tests_run += 6;
            if (i_req_r !== exp_rr) begin tests_failed++; $display("FAIL req_ready: got %b expected %b", i_req_r, exp_rr); end
            if (i_hrsp_r !== (!m_rsp_v || o_rsp_r)) begin tests_failed++; $display("FAIL hrsp_ready: got %b expected %b", i_hrsp_r, (!m_rsp_v || o_rsp_r)); end
            if (o_cmd_v !== m_cmd_v) begin tests_failed++; $display("FAIL cmd_valid: got %b expected %b", o_cmd_v, m_cmd_v); end
            if (o_rsp_v !== m_rsp_v) begin tests_failed++; $display("FAIL rsp_valid: got %b expected %b", o_rsp_v, m_rsp_v); end
            if (o_err !== m_err) begin tests_failed++; $display("FAIL err: got %b expected %b", o_err, m_err); end
            if (o_idle !== ((&m_free) && !m_cmd_v && !m_rsp_v)) begin
                tests_failed++; $display("FAIL idle: got %b expected %b", o_idle, ((&m_free) && !m_cmd_v && !m_rsp_v));
            end
            if (o_cmd_v && o_cmd_r) begin
                logic [68:0] e;
                tests_run++;
                if (cmd_q.size() == 0) begin
                    tests_failed++; $display("FAIL cmd_unexpected: got tag %0d with empty scoreboard", o_cmd_tag);
                end else begin
                    e = cmd_q.pop_front();
                    if (o_cmd_tag !== e[68:64] || o_cmd_ea !== e[63:0]) begin
                        tests_failed++;
                        $display("FAIL cmd_data: got tag %0d ea %h expected tag %0d ea %h", o_cmd_tag, o_cmd_ea, e[68:64], e[63:0]);
                    end
                end
            end
            if (o_rsp_v && o_rsp_r) begin
                logic [5:0] s;
                tests_run++;
                if (rsp_q.size() == 0) begin
                    tests_failed++; $display("FAIL rsp_unexpected: got sid %0d with empty scoreboard", o_rsp_sid);
                end else begin
                    s = rsp_q.pop_front();
                    if (o_rsp_sid !== s) begin tests_failed++; $display("FAIL rsp_sid: got %0d expected %0d", o_rsp_sid, s); end
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        i_req_v = 1'b0; i_req_sid = 6'd0; i_req_ea = 64'd0; o_cmd_r = 1'b0;
        i_crd_v = 1'b0; i_hrsp_v = 1'b0; i_hrsp_tag = 5'd0; o_rsp_r = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
        #1;
        tests_run += 3;
        if (o_cmd_v !== 1'b0 || o_rsp_v !== 1'b0 || o_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_flags: got cmd_v %b rsp_v %b err %b expected 0 0 0", o_cmd_v, o_rsp_v, o_err);
        end
        if (o_cmd_tag !== 5'd0 || o_cmd_ea !== 64'd0 || o_rsp_sid !== 6'd0) begin
            tests_failed++; $display("FAIL reset_data: got tag %0d ea %h sid %0d expected 0 0 0", o_cmd_tag, o_cmd_ea, o_rsp_sid);
        end
        if (o_idle !== 1'b1 || i_req_r !== 1'b1 || i_hrsp_r !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready: got idle %b req_r %b hrsp_r %b expected 1 1 1", o_idle, i_req_r, i_hrsp_r);
        end
    endtask

    task automatic test_basic();
        logic [5:0]  sids [4];
        logic [63:0] eas  [4];
        logic [63:0] exp_ea [4];
        sids = '{6'd3, 6'd7, 6'd9, 6'd63};
        eas  = '{64'h1000_007F, 64'h2000_0080, 64'h3000_00FF, 64'hFFFF_FFFF_FFFF_FFFF};
        exp_ea = '{64'h1000_0000, 64'h2000_0080, 64'h3000_0080, 64'hFFFF_FFFF_FFFF_FF80};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, sids[i], eas[i], 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
            tests_run++;
            if (o_cmd_v !== 1'b1 || o_cmd_tag !== 5'(i) || o_cmd_ea !== exp_ea[i]) begin
                tests_failed++;
                $display("FAIL basic_cmd: got v %b tag %0d ea %h expected 1 %0d %h", o_cmd_v, o_cmd_tag, o_cmd_ea, i, exp_ea[i]);
            end
        end
        idle_cycle();
        for (int t = 0; t < 4; t++) begin
            drive(1'b0, 6'd0, 64'd0, 1'b1, 1'b1, 1'b1, 5'(t), 1'b1);
            tests_run++;
            if (o_rsp_v !== 1'b1 || o_rsp_sid !== sids[t]) begin
                tests_failed++; $display("FAIL basic_rsp: got v %b sid %0d expected 1 %0d", o_rsp_v, o_rsp_sid, sids[t]);
            end
        end
        idle_cycle();
        tests_run++;
        if (o_idle !== 1'b1) begin tests_failed++; $display("FAIL basic_idle: got %b expected 1", o_idle); end
    endtask

    task automatic test_credits();
        int cnt;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i_req_r === 1'b1) cnt++;
            drive(1'b1, 6'(i), 64'(i) << 7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        end
        tests_run += 2;
        if (cnt !== 16) begin tests_failed++; $display("FAIL credit_count: got %0d accepted expected 16", cnt); end
        if (i_req_r !== 1'b0) begin tests_failed++; $display("FAIL credit_block: got req_r %b expected 0", i_req_r); end
        drive(1'b1, 6'd20, 64'h5000, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
        tests_run++;
        if (i_req_r !== 1'b1) begin tests_failed++; $display("FAIL credit_return: got req_r %b expected 1", i_req_r); end
        drive(1'b1, 6'd20, 64'h5000, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        tests_run++;
        if (o_cmd_tag !== 5'd16) begin tests_failed++; $display("FAIL credit_tag: got %0d expected 16", o_cmd_tag); end
        idle_cycle();
        for (int t = 0; t < 17; t++) drive(1'b0, 6'd0, 64'd0, 1'b1, (t < 16), 1'b1, 5'(t), 1'b1);
        idle_cycle();
    endtask

    task automatic test_tags_exhausted();
        for (int i = 0; i < 32; i++)
            drive(1'b1, 6'(i + 10), (64'(i) << 12) | 64'h55, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
        tests_run++;
        if (i_req_r !== 1'b0) begin tests_failed++; $display("FAIL tags_block: got req_r %b expected 0", i_req_r); end
        drive(1'b1, 6'd50, 64'hA000, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1);
        tests_run += 2;
        if (o_rsp_v !== 1'b1 || o_rsp_sid !== 6'd12) begin
            tests_failed++; $display("FAIL tags_rsp: got v %b sid %0d expected 1 12", o_rsp_v, o_rsp_sid);
        end
        if (i_req_r !== 1'b1) begin tests_failed++; $display("FAIL tags_reopen: got req_r %b expected 1", i_req_r); end
        drive(1'b1, 6'd50, 64'hA000, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        tests_run++;
        if (o_cmd_tag !== 5'd2) begin tests_failed++; $display("FAIL tags_reuse: got %0d expected 2", o_cmd_tag); end
        idle_cycle();
        for (int t = 0; t < 32; t++) drive(1'b0, 6'd0, 64'd0, 1'b1, (t == 0), 1'b1, 5'(t), 1'b1);
        idle_cycle();
    endtask

    task automatic test_cmd_stall();
        drive(1'b1, 6'd5, 64'hABCD_0123, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 6'd6, 64'h7777_0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
            tests_run++;
            if (o_cmd_v !== 1'b1 || o_cmd_tag !== 5'd0 || o_cmd_ea !== 64'hABCD_0100 || i_req_r !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold: got v %b tag %0d ea %h req_r %b expected 1 0 abcd0100 0", o_cmd_v, o_cmd_tag, o_cmd_ea, i_req_r);
            end
        end
        drive(1'b1, 6'd6, 64'h7777_0000, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        tests_run++;
        if (o_cmd_tag !== 5'd1 || o_cmd_ea !== 64'h7777_0000) begin
            tests_failed++; $display("FAIL stall_resume: got tag %0d ea %h expected 1 77770000", o_cmd_tag, o_cmd_ea);
        end
        drive(1'b1, 6'd7, 64'h8888_00C0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        idle_cycle();
        for (int t = 0; t < 3; t++) drive(1'b0, 6'd0, 64'd0, 1'b1, 1'b1, 1'b1, 5'(t), 1'b1);
        idle_cycle();
    endtask

    task automatic test_concurrent();
        drive(1'b1, 6'd33, 64'h9000, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 6'd34, 64'h9100, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
        tests_run++;
        if (o_rsp_v !== 1'b1 || o_rsp_sid !== 6'd33 || o_cmd_tag !== 5'd1) begin
            tests_failed++; $display("FAIL conc_both: got rsp_v %b sid %0d tag %0d expected 1 33 1", o_rsp_v, o_rsp_sid, o_cmd_tag);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0);
            tests_run++;
            if (o_rsp_v !== 1'b1 || o_rsp_sid !== 6'd33) begin
                tests_failed++; $display("FAIL conc_hold: got v %b sid %0d expected 1 33", o_rsp_v, o_rsp_sid);
            end
        end
        drive(1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1);
        tests_run++;
        if (o_rsp_v !== 1'b1 || o_rsp_sid !== 6'd34) begin
            tests_failed++; $display("FAIL conc_next: got v %b sid %0d expected 1 34", o_rsp_v, o_rsp_sid);
        end
        drive(1'b0, 6'd0, 64'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
        tests_run++;
        if (o_rsp_v !== 1'b0 || o_idle !== 1'b1) begin
            tests_failed++; $display("FAIL conc_drain: got rsp_v %b idle %b expected 0 1", o_rsp_v, o_idle);
        end
    endtask

    task automatic test_err();
        int cnt;
        drive(1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
        tests_run++;
        if (o_rsp_v !== 1'b0 || o_err !== 1'b1) begin
            tests_failed++; $display("FAIL err_free_tag: got rsp_v %b err %b expected 0 1", o_rsp_v, o_err);
        end
        drive(1'b0, 6'd0, 64'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 17; i++) begin
            if (i_req_r === 1'b1) cnt++;
            drive(1'b1, 6'(i), 64'h2_0000 + (64'(i) << 7), 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        end
        tests_run += 2;
        if (cnt !== 16) begin tests_failed++; $display("FAIL err_saturate: got %0d accepted expected 16", cnt); end
        if (o_err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b expected 1", o_err); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 6'd0, 64'd0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0);
        drive(1'b1, 6'd44, 64'hC000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tests_run++;
        if (o_cmd_v !== 1'b1 || o_rsp_v !== 1'b1) begin
            tests_failed++; $display("FAIL mid_setup: got cmd_v %b rsp_v %b expected 1 1", o_cmd_v, o_rsp_v);
        end
        reset = 1'b1;
        i_req_v = 1'b0; o_cmd_r = 1'b0; i_crd_v = 1'b0; i_hrsp_v = 1'b0; o_rsp_r = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (o_cmd_v !== 1'b0 || o_rsp_v !== 1'b0) begin
            tests_failed++; $display("FAIL mid_drop: got cmd_v %b rsp_v %b expected 0 0", o_cmd_v, o_rsp_v);
        end
        model_reset();
        reset = 1'b0;
        #1;
        tests_run++;
        if (o_err !== 1'b0 || o_idle !== 1'b1 || i_req_r !== 1'b1) begin
            tests_failed++; $display("FAIL mid_state: got err %b idle %b req_r %b expected 0 1 1", o_err, o_idle, i_req_r);
        end
        drive(1'b1, 6'd9, 64'hD0FF, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        tests_run++;
        if (o_cmd_tag !== 5'd0 || o_cmd_ea !== 64'hD080) begin
            tests_failed++; $display("FAIL mid_realloc: got tag %0d ea %h expected 0 d080", o_cmd_tag, o_cmd_ea);
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_credits();
        test_tags_exhausted();
        test_cmd_stall();
        test_concurrent();
        test_err();
        test_reset_mid();
        tests_run++;
        if (cmd_q.size() != 0 || rsp_q.size() != 0) begin
            tests_failed++; $display("FAIL leftover: got %0d cmds %0d rsps pending expected 0 0", cmd_q.size(), rsp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/l2_host_req_tracker.md
# l2_host_req_tracker

Host request tracker directly downstream of the L2 stream controller's host request port. It accepts merged per-stream cache-line fetch requests, allocates a host tag, and issues tagged commands under host command credits. It records the stream ID per tag and, on each tagged host response, frees the tag and returns the stream ID upstream as the L2 response.

## Interface
- addr_width, 64, host address width in bits
- cache_line, 128, host cache line size in bytes; cache_line_width = $clog2(cache_line)
- nstrms, 64, number of streams; nstrms_width = $clog2(nstrms)
- ntags, 32, outstanding host tags (power of two, ≥2); ntags_width = $clog2(ntags)
- ncredits, 16, initial host command credits (1..255); crd_width = 8

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req_v  in  1  request valid from L2 controller
- i_req_r  out  1  request ready
- i_req_sid  in  nstrms_width  requesting stream ID
- i_req_ea  in  addr_width  request effective address
- o_cmd_v  out  1  host command valid
- o_cmd_r  in  1  host command ready
- o_cmd_tag  out  ntags_width  allocated tag
- o_cmd_ea  out  addr_width  cache-line-aligned EA
- i_crd_v  in  1  host returns one command credit this cycle
- i_hrsp_v  in  1  host response valid
- i_hrsp_r  out  1  host response ready
- i_hrsp_tag  in  ntags_width  responding tag
- o_rsp_v  out  1  response valid to L2 controller
- o_rsp_r  in  1  response ready
- o_rsp_sid  out  nstrms_width  stream ID of completed request
- o_idle  out  1  no tags outstanding, no output valid
- o_err  out  1  sticky protocol error

## Operation
- State: free bitmap free[ntags] (1 = free), sid table sid_tab[ntags], credit counter crd, command output register, response output register, o_err.
- Allocation: lowest-index free tag (priority encode of free). can_issue = |free && crd != 0 && (!o_cmd_v || o_cmd_r).
- i_req_r = can_issue. On i_req_v && i_req_r: free[tag] <= 0, sid_tab[tag] <= i_req_sid, crd decrements, command register loads {tag, i_req_ea with low cache_line_width bits zeroed}, o_cmd_v <= 1.
- o_cmd_v/o_cmd_tag/o_cmd_ea hold stable while o_cmd_v && !o_cmd_r; o_cmd_v clears on o_cmd_r unless a new request loads the same cycle.
- Credits: i_crd_v increments crd; simultaneous consume and return leaves crd unchanged. Return with crd == ncredits and no consume: crd saturates, o_err <= 1.
- Response: i_hrsp_r = !o_rsp_v || o_rsp_r. On i_hrsp_v && i_hrsp_r: if free[i_hrsp_tag] == 0, free[tag] <= 1, o_rsp_sid <= sid_tab[tag], o_rsp_v <= 1; if tag already free, response dropped (no o_rsp_v), o_err <= 1.
- o_rsp_v clears on o_rsp_r unless a new response loads the same cycle.
- Simultaneous allocate and free: always distinct tags (allocated tag is free, freed tag is not); both apply. Freed tag is eligible for allocation from the next cycle, never the same cycle.
- o_idle = &free && !o_cmd_v && !o_rsp_v.
- o_err cleared only by reset.

## Timing
- Reset: free = all ones, crd = ncredits, o_cmd_v = 0, o_rsp_v = 0, o_err = 0, o_cmd_tag/o_cmd_ea/o_rsp_sid = 0, o_idle = 1. sid_tab not reset.
- Request-to-command latency 1 cycle; full throughput 1 request/cycle while tags and credits are available and o_cmd_r = 1.
- Host-response-to-L2-response latency 1 cycle; throughput 1/cycle with o_rsp_r = 1.
- i_req_r and i_hrsp_r are combinational from registered state and o_cmd_r/o_rsp_r only; never depend on i_req_v/i_hrsp_v.
- Tags exhausted: i_req_r = 0 until a response is accepted, then 1 the following cycle. crd == 0: i_req_r = 0; a credit returned in cycle N gives i_req_r = 1 in cycle N+1.
- Reset mid-operation: all outstanding tags are abandoned, in-flight outputs drop the cycle after reset asserts, and state reinitializes as above.

## Test plan
- Reset then 4 requests (sid 3,7,9,63, ea 0x1000_007F etc.) with o_cmd_r=1 -> tags 0,1,2,3 on consecutive cycles, o_cmd_ea = 0x1000_0000, crd=12.
- ncredits=16, 20 back-to-back requests with no credit return -> exactly 16 accepted, i_req_r=0; one i_crd_v -> 17th accepted next cycle with tag 16.
- ntags=4 stub config with 4 outstanding -> i_req_r=0; response tag 2 accepted -> o_rsp_sid = sid of tag 2 one cycle later; next request gets tag 2.
- o_cmd_r held 0 for 5 cycles -> o_cmd_v/tag/ea stable, i_req_r=0; release -> command issues, flow resumes.
- Response to a free tag 5 -> no o_rsp_v, o_err=1 sticky; credit return at crd=16 -> crd stays 16, o_err=1.
- Same-cycle request accept, response accept, and credit return with o_rsp_r=0 then 1 -> crd unchanged, o_rsp_v held until o_rsp_r, no lost or duplicated response.
